// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   Receive-side capture for 8N1 UART frames. The RX line is synchronised, each bit is
//   sampled near its middle, and each good byte goes into a one-entry holding register.
//   VALID/CLEAR is the handshake with the consumer. FRAME_ERR and OVERRUN are sticky
//   error flags.
// Parameters
//   CLKS_PER_BIT  clocks per bit period (>= 4)
//   SYNC_STAGES   synchroniser depth on RX (>= 2)
// Ports
//   CLK_100MHz  in   system clock, rising edge
//   RESET_N     in   synchronous active-low reset
//   RX          in   asynchronous serial input, idle high
//   CLEAR       in   one-cycle pulse: consumer took DATA; clears VALID and the error flags
//   DATA        out  [7:0] last good byte received
//   VALID       out  DATA holds an unread byte
//   FRAME_ERR   out  sticky: a stop bit was sampled low
//   OVERRUN     out  sticky: a good byte was dropped because VALID was still set
//   RX_BUSY     out  FSM is not idle (registered)
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       CLK_100MHz,
  input  logic       RESET_N,
  input  logic       RX,
  input  logic       CLEAR,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       RX_BUSY
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic [2:0]             idx_q;
  logic [7:0]             shift_q;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK_100MHz) begin
    if (!RESET_N) begin
      sync_q    <= '1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      RX_BUSY   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
      cnt_q  <= cnt_q + CntW'(1);

      // The consumer's CLEAR is applied first. A good capture below in the same cycle
      // overrides it, so the new byte loads and VALID stays high.
      if (CLEAR) begin
        VALID     <= 1'b0;
        FRAME_ERR <= 1'b0;
        OVERRUN   <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rxs) begin
            state_q <= StStart;
            RX_BUSY <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == HalfM1) begin
            cnt_q <= '0;
            if (!rxs) begin
              state_q <= StData;
              idx_q   <= '0;
            end else begin
              // The start bit did not last to mid-bit, so treat the low as a glitch.
              state_q <= StIdle;
              RX_BUSY <= 1'b0;
            end
          end
        end
        StData: begin
          if (cnt_q == FullM1) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (cnt_q == FullM1) begin
            cnt_q <= '0;
            if (rxs) begin
              // Return to idle at mid stop bit so a back-to-back start edge is not missed.
              state_q <= StIdle;
              RX_BUSY <= 1'b0;
              if (!VALID || CLEAR) begin
                DATA  <= shift_q;
                VALID <= 1'b1;
              end else begin
                OVERRUN <= 1'b1;
              end
            end else begin
              FRAME_ERR <= 1'b1;
              state_q   <= StBreak;
            end
          end
        end
        StBreak: begin
          // Hold here until the line goes high, so a held-low line cannot retrigger.
          cnt_q <= '0;
          if (rxs) begin
            state_q <= StIdle;
            RX_BUSY <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          RX_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture with CLKS_PER_BIT=16. RX is driven by an ideal 8N1
// model, with one RX change per clock just after the rising edge.
module tb_uart_rx_capture;

  localparam int unsigned Cpb = 16;
  localparam int FrameCycles = 10 * Cpb;
  // Cycle index within a frame whose edge performs the mid-stop capture:
  // 2 sync + 16/2 start + 9*16 + 1 = 155, so CLEAR must be high in iteration 154.
  localparam int CapCyc = 155;

  logic       CLK_100MHz = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       RX         = 1'b1;
  logic       CLEAR      = 1'b0;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       RX_BUSY;

  int checks = 0;
  int errors = 0;
  logic v_before, v_at;

  uart_rx_capture #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_100MHz(CLK_100MHz),
    .RESET_N   (RESET_N),
    .RX        (RX),
    .CLEAR     (CLEAR),
    .DATA      (DATA),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .RX_BUSY   (RX_BUSY)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  task automatic step();
    @(posedge CLK_100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive ncyc cycles of an 8N1 frame. CLEAR is high during iteration clr_cyc (-1 = never).
  // VALID is recorded just before and just after the expected capture edge.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int clr_cyc,
                             input int ncyc, output logic vb, output logic va);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    vb = 1'bx;
    va = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      if (c == CapCyc - 1) vb = VALID;
      if (c == CapCyc) va = VALID;
      RX    = frame[c / Cpb];
      CLEAR = (c == clr_cyc);
      step();
    end
    CLEAR = 1'b0;
    RX    = 1'b1;
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
  endtask

  initial begin
    // 1 Reset with RX toggling.
    for (int i = 0; i < 5; i++) begin
      step();
      RX = ~RX;
    end
    check("rst_data", DATA, 8'h00);
    check("rst_valid", VALID, 1'b0);
    check("rst_ferr", FRAME_ERR, 1'b0);
    check("rst_ovr", OVERRUN, 1'b0);
    check("rst_busy", RX_BUSY, 1'b0);
    RESET_N = 1'b1;
    RX      = 1'b1;
    repeat (20) step();
    check("idle_valid", VALID, 1'b0);
    check("idle_busy", RX_BUSY, 1'b0);
    check("idle_data", DATA, 8'h00);

    // 2 Single byte, exact latency, then CLEAR.
    drive_frame(8'hAB, 1'b1, -1, FrameCycles, v_before, v_at);
    check("lat_before", v_before, 1'b0);
    check("lat_at", v_at, 1'b1);
    check("ab_data", DATA, 8'hAB);
    check("ab_valid", VALID, 1'b1);
    check("ab_ferr", FRAME_ERR, 1'b0);
    check("ab_busy", RX_BUSY, 1'b0);
    pulse_clear();
    check("clr_valid", VALID, 1'b0);
    check("clr_data", DATA, 8'hAB);

    // 3 Back-to-back frames: overrun, then CLEAR on the capture cycle.
    drive_frame(8'hAB, 1'b1, -1, FrameCycles, v_before, v_at);
    drive_frame(8'hCD, 1'b1, -1, FrameCycles, v_before, v_at);
    check("ovr_data", DATA, 8'hAB);
    check("ovr_valid", VALID, 1'b1);
    check("ovr_flag", OVERRUN, 1'b1);
    pulse_clear();
    check("ovr_clr_flag", OVERRUN, 1'b0);
    check("ovr_clr_valid", VALID, 1'b0);
    drive_frame(8'hAB, 1'b1, -1, FrameCycles, v_before, v_at);
    drive_frame(8'hCD, 1'b1, CapCyc - 1, FrameCycles, v_before, v_at);
    check("cc_data", DATA, 8'hCD);
    check("cc_valid", VALID, 1'b1);
    check("cc_ovr", OVERRUN, 1'b0);
    pulse_clear();

    // 4 Framing error, held-low line, then recovery.
    drive_frame(8'h55, 1'b0, -1, FrameCycles, v_before, v_at);
    RX = 1'b0;
    repeat (40) step();
    check("fe_flag", FRAME_ERR, 1'b1);
    check("fe_valid", VALID, 1'b0);
    check("fe_busy_break", RX_BUSY, 1'b1);
    check("fe_data", DATA, 8'hCD);
    RX = 1'b1;
    repeat (5) step();
    check("brk_exit_busy", RX_BUSY, 1'b0);
    drive_frame(8'h3C, 1'b1, -1, FrameCycles, v_before, v_at);
    check("rec_data", DATA, 8'h3C);
    check("rec_valid", VALID, 1'b1);
    check("rec_ferr_sticky", FRAME_ERR, 1'b1);
    pulse_clear();
    check("rec_clr_ferr", FRAME_ERR, 1'b0);
    check("rec_clr_valid", VALID, 1'b0);

    // 5 Three-cycle glitch.
    RX = 1'b0;
    repeat (3) step();
    RX = 1'b1;
    repeat (2) step();
    check("gl_busy_start", RX_BUSY, 1'b1);
    repeat (20) step();
    check("gl_busy", RX_BUSY, 1'b0);
    check("gl_valid", VALID, 1'b0);
    check("gl_ferr", FRAME_ERR, 1'b0);
    check("gl_ovr", OVERRUN, 1'b0);

    // 6 Reset in the middle of a frame, then a clean frame.
    drive_frame(8'hF0, 1'b1, -1, 5 * Cpb, v_before, v_at);
    check("mid_busy", RX_BUSY, 1'b1);
    RESET_N = 1'b0;
    repeat (2) step();
    RESET_N = 1'b1;
    check("mr_busy", RX_BUSY, 1'b0);
    check("mr_valid", VALID, 1'b0);
    check("mr_data", DATA, 8'h00);
    repeat (5) step();
    drive_frame(8'h0F, 1'b1, -1, FrameCycles, v_before, v_at);
    check("post_data", DATA, 8'h0F);
    check("post_valid", VALID, 1'b1);
    check("post_ferr", FRAME_ERR, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
